mem_boot_banked: RTL

- Unified instruction/data memory with a runtime boot-loader port, replacing the simulation-only hex preload of the current memory.
- After reset it accepts a word stream into the array, then serves FETCH_LANES consecutive instruction words per cycle to decode and one sized load/store port to the LSU.
- Parametrised in depth and fetch width; adds a load checksum, a reload request and misalignment reporting.

---
 rtl/mem_boot_banked.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_boot_banked.sv
// Unified instruction/data memory loaded at runtime through a boot-word stream,
// then serving multi-lane instruction fetch and one sized load/store port.
module mem_boot_banked #(
  parameter int          FETCH_LANES = 2,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          ADDR_W      = 64,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              io_load_valid,
  output logic                              io_load_ready,
  input  logic [31:0]                       io_load_data,
  input  logic                              io_load_last,
  input  logic                              io_reload,
  output logic                              io_load_done,
  output logic [31:0]                       io_load_checksum,
  output logic [$clog2(DEPTH_WORDS):0]      io_load_count,
  input  logic [ADDR_W-1:0]                 io_if_mem_instAddr,
  output logic [32*FETCH_LANES-1:0]         io_mem_id_inst,
  input  logic [ADDR_W-1:0]                 io_ex_mem_dataAddr,
  input  logic                              io_ex_mem_writeEn,
  input  logic [31:0]                       io_ex_mem_writeData,
  input  logic [2:0]                        io_ex_mem_func3,
  output logic [31:0]                       io_mem_lsu_data,
  output logic                              io_mem_misaligned
);

  // state | meaning
  // LOAD  | accepting boot words, fetch returns NOP_WORD, stores ignored
  // RUN   | array live for fetch and load/store, reload pulse returns to LOAD
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [31:0]              csum_q, csum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [32*FETCH_LANES-1:0] inst_q, inst_d;
  logic [31:0]              lsu_q, lsu_d;
  logic                     mis_q, mis_d;
  logic [31:0]              mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] fetch_idx, data_idx;
  logic [1:0]       off;
  logic             load_hs, mis_raw, st_we;
  logic [3:0]       st_be;
  logic [31:0]      st_data, rd_word, rd_shift;
  logic             unused_addr_bits;

  assign fetch_idx = io_if_mem_instAddr[IDX_W+1:2];
  assign data_idx  = io_ex_mem_dataAddr[IDX_W+1:2];
  assign off       = io_ex_mem_dataAddr[1:0];
  assign load_hs   = (state_q == S_LOAD) && io_load_valid;
  assign unused_addr_bits = ^{io_if_mem_instAddr[ADDR_W-1:IDX_W+2], io_if_mem_instAddr[1:0],
                              io_ex_mem_dataAddr[ADDR_W-1:IDX_W+2]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (io_load_valid) begin
          ptr_d  = ptr_q + IDX_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          csum_d = csum_q + io_load_data;
          if (io_load_last || ptr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (io_reload) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // LHU shares the half-word alignment rule only as a load; 101 is not a store
  always_comb begin
    mis_raw = 1'b0;
    case (io_ex_mem_func3)
      3'b001:  mis_raw = off[0];
      3'b101:  mis_raw = off[0] && !io_ex_mem_writeEn;
      3'b010:  mis_raw = |off;
      default: mis_raw = 1'b0;
    endcase
    mis_d = mis_raw && (!io_ex_mem_writeEn || state_q == S_RUN);
  end

  always_comb begin
    rd_word  = mem_q[data_idx];
    rd_shift = rd_word >> {off, 3'b000};
    lsu_d    = lsu_q;
    if (!io_ex_mem_writeEn) begin
      if (mis_raw) lsu_d = '0;
      else begin
        case (io_ex_mem_func3)
          3'b000:  lsu_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
          3'b001:  lsu_d = {{16{rd_shift[15]}}, rd_shift[15:0]};
          3'b010:  lsu_d = rd_word;
          3'b100:  lsu_d = {24'd0, rd_shift[7:0]};
          3'b101:  lsu_d = {16'd0, rd_shift[15:0]};
          default: lsu_d = '0;
        endcase
      end
    end
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = io_ex_mem_writeData;
    case (io_ex_mem_func3)
      3'b000: begin
        st_be   = 4'b0001 << off;
        st_data = {4{io_ex_mem_writeData[7:0]}};
      end
      3'b001: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{io_ex_mem_writeData[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
    st_we = (state_q == S_RUN) && io_ex_mem_writeEn && !mis_raw && (|st_be);
  end

  always_comb begin
    inst_d = '0;
    for (int k = 0; k < FETCH_LANES; k++) begin
      inst_d[32*k +: 32] = (state_q == S_RUN) ? mem_q[fetch_idx + IDX_W'(k)] : NOP_WORD;
    end
  end

  // Array has no reset; reads above see pre-write contents (read-first)
  always_ff @(posedge clock) begin
    if (load_hs) mem_q[ptr_q] <= io_load_data;
    else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem_q[data_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      inst_q  <= {FETCH_LANES{NOP_WORD}};
      lsu_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      lsu_q   <= lsu_d;
      mis_q   <= mis_d;
    end
  end

  assign io_load_ready    = (state_q == S_LOAD);
  assign io_load_done     = (state_q == S_RUN);
  assign io_load_checksum = csum_q;
  assign io_load_count    = cnt_q;
  assign io_mem_id_inst   = inst_q;
  assign io_mem_lsu_data  = lsu_q;
  assign io_mem_misaligned = mis_q;

endmodule
